// File: rtl/i2c_master_avalon.sv
// I2C master with an Avalon-MM register front end.
// Sends or receives 1..4 bytes to/from one 7-bit slave address per transaction.
// The scl/sda pins are open-drain: the block only ever pulls low or releases.
module i2c_master_avalon #(
  parameter int CLK_DIV = 125
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  address,
  input  logic        write,
  input  logic [31:0] writedata,
  input  logic        read,
  output logic [31:0] readdata,
  inout  wire         scl,
  inout  wire         sda
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_START,
    S_ADDR,
    S_ADDR_ACK,
    S_TX_BYTE,
    S_TX_ACK,
    S_RX_BYTE,
    S_RX_ACK,
    S_STOP
  } state_t;

  localparam logic [15:0] DIV_M1 = 16'(CLK_DIV - 1);

  // Register file
  logic [6:0]  r_slave_addr;
  logic [31:0] r_tx_data;
  logic [31:0] r_rx_data;
  logic [31:0] r_readdata;
  logic        r_rnw;
  logic [1:0]  r_nbytes_m1;
  logic        r_ack_error;
  logic        r_busy;

  // Bit engine
  state_t      r_state;
  logic [15:0] r_div;
  logic [1:0]  r_phase;
  logic [2:0]  r_bit_cnt;
  logic [1:0]  r_byte_cnt;
  logic [7:0]  r_shift;
  logic        r_ack_sample;
  logic        r_scl_low;
  logic        r_sda_low;

  logic        w_scl_in;
  logic        w_sda_in;
  logic        w_start;
  logic        w_hold;
  logic        w_tick;
  logic        w_last_byte;
  logic [1:0]  w_byte_nxt;
  logic [7:0]  w_tx_next;

  assign scl      = r_scl_low ? 1'b0 : 1'bz;
  assign sda      = r_sda_low ? 1'b0 : 1'bz;
  assign w_scl_in = scl;
  assign w_sda_in = sda;
  assign readdata = r_readdata;

  // A start request is only honoured while no transaction is in flight.
  assign w_start     = write && (address == 2'd2) && writedata[0] && !r_busy;
  // A slave holding SCL low during the released phase freezes the bit timing.
  assign w_hold      = (r_phase == 2'd2) && !w_scl_in;
  assign w_tick      = r_busy && !w_hold && (r_div == DIV_M1);
  assign w_last_byte = (r_byte_cnt == r_nbytes_m1);
  assign w_byte_nxt  = r_byte_cnt + 2'd1;
  assign w_tx_next   = r_tx_data[{w_byte_nxt, 3'b000} +: 8];

  // Registered read port, one cycle latency, reads never alter state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_readdata <= 32'd0;
    end else if (read) begin
      case (address)
        2'd0:    r_readdata <= {25'd0, r_slave_addr};
        2'd1:    r_readdata <= r_tx_data;
        2'd2:    r_readdata <= {30'd0, r_ack_error, r_busy};
        default: r_readdata <= r_rx_data;
      endcase
    end
  end

  // Address and transmit data are frozen while a transaction runs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_slave_addr <= 7'd0;
      r_tx_data    <= 32'd0;
    end else if (write && !r_busy) begin
      if (address == 2'd0) r_slave_addr <= writedata[6:0];
      if (address == 2'd1) r_tx_data    <= writedata;
    end
  end

  // Quarter-period divider, restarted at every start and idle otherwise.
  always_ff @(posedge clk) begin
    if (reset || w_start || !r_busy) begin
      r_div <= 16'd0;
    end else if (!w_hold) begin
      r_div <= (r_div == DIV_M1) ? 16'd0 : r_div + 16'd1;
    end
  end

  // Transaction FSM: advances one phase per tick, drives the pins from registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_phase      <= 2'd0;
      r_busy       <= 1'b0;
      r_ack_error  <= 1'b0;
      r_rx_data    <= 32'd0;
      r_rnw        <= 1'b0;
      r_nbytes_m1  <= 2'd0;
      r_bit_cnt    <= 3'd0;
      r_byte_cnt   <= 2'd0;
      r_shift      <= 8'd0;
      r_ack_sample <= 1'b0;
      r_scl_low    <= 1'b0;
      r_sda_low    <= 1'b0;
    end else if (w_start) begin
      r_state     <= S_START;
      r_phase     <= 2'd0;
      r_busy      <= 1'b1;
      r_ack_error <= 1'b0;
      r_rx_data   <= 32'd0;
      r_rnw       <= writedata[1];
      r_nbytes_m1 <= writedata[3:2];
      r_bit_cnt   <= 3'd0;
      r_byte_cnt  <= 2'd0;
      r_scl_low   <= 1'b0;
      r_sda_low   <= 1'b0;
    end else if (w_tick) begin
      r_phase <= r_phase + 2'd1;
      case (r_phase)
        2'd1: begin
          // Entering p2: SCL released; START pulls SDA low under a high SCL.
          r_scl_low <= 1'b0;
          if (r_state == S_START) r_sda_low <= 1'b1;
        end
        2'd2: begin
          // Last cycle of p2 is the SDA sampling point.
          case (r_state)
            S_ADDR_ACK, S_TX_ACK: r_ack_sample <= w_sda_in;
            S_RX_BYTE:            r_shift      <= {r_shift[6:0], w_sda_in};
            S_STOP:               r_sda_low    <= 1'b0;
            default:              ;
          endcase
        end
        2'd3: begin
          // Slot boundary: SCL goes low and SDA takes the next slot's value.
          r_scl_low <= 1'b1;
          case (r_state)
            S_START: begin
              r_state   <= S_ADDR;
              r_shift   <= {r_slave_addr, r_rnw};
              r_bit_cnt <= 3'd0;
              r_sda_low <= ~r_slave_addr[6];
            end
            S_ADDR, S_TX_BYTE: begin
              if (r_bit_cnt == 3'd7) begin
                r_state   <= (r_state == S_ADDR) ? S_ADDR_ACK : S_TX_ACK;
                r_sda_low <= 1'b0;
              end else begin
                r_bit_cnt <= r_bit_cnt + 3'd1;
                r_shift   <= {r_shift[6:0], 1'b0};
                r_sda_low <= ~r_shift[6];
              end
            end
            S_ADDR_ACK: begin
              r_bit_cnt  <= 3'd0;
              r_byte_cnt <= 2'd0;
              if (r_ack_sample) begin
                r_ack_error <= 1'b1;
                r_state     <= S_STOP;
                r_sda_low   <= 1'b1;
              end else if (r_rnw) begin
                r_state   <= S_RX_BYTE;
                r_sda_low <= 1'b0;
              end else begin
                r_state   <= S_TX_BYTE;
                r_shift   <= r_tx_data[7:0];
                r_sda_low <= ~r_tx_data[7];
              end
            end
            S_TX_ACK: begin
              if (r_ack_sample || w_last_byte) begin
                r_ack_error <= r_ack_sample;
                r_state     <= S_STOP;
                r_sda_low   <= 1'b1;
              end else begin
                r_state    <= S_TX_BYTE;
                r_byte_cnt <= w_byte_nxt;
                r_bit_cnt  <= 3'd0;
                r_shift    <= w_tx_next;
                r_sda_low  <= ~w_tx_next[7];
              end
            end
            S_RX_BYTE: begin
              if (r_bit_cnt == 3'd7) begin
                r_state <= S_RX_ACK;
                r_rx_data[{r_byte_cnt, 3'b000} +: 8] <= r_shift;
                // ACK every byte except the last, which is NACKed.
                r_sda_low <= !w_last_byte;
              end else begin
                r_bit_cnt <= r_bit_cnt + 3'd1;
                r_sda_low <= 1'b0;
              end
            end
            S_RX_ACK: begin
              if (w_last_byte) begin
                r_state   <= S_STOP;
                r_sda_low <= 1'b1;
              end else begin
                r_state    <= S_RX_BYTE;
                r_byte_cnt <= w_byte_nxt;
                r_bit_cnt  <= 3'd0;
                r_sda_low  <= 1'b0;
              end
            end
            default: begin
              // End of STOP: both lines stay released and the block goes idle.
              r_state   <= S_IDLE;
              r_busy    <= 1'b0;
              r_scl_low <= 1'b0;
              r_sda_low <= 1'b0;
            end
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_master_avalon.sv
// Directed bench for i2c_master_avalon with a behavioural I2C slave on the bus.
module tb_i2c_master_avalon;

  localparam logic [6:0] SLV = 7'h50;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  address;
  logic        write;
  logic [31:0] writedata;
  logic        read;
  logic [31:0] readdata;
  wire         scl;
  wire         sda;

  logic tb_scl_low = 1'b0;
  logic sl_low     = 1'b0;
  logic sl_present = 1'b1;

  assign scl = tb_scl_low ? 1'b0 : 1'bz;
  assign sda = sl_low ? 1'b0 : 1'bz;
  pullup (scl);
  pullup (sda);

  always #5 clk = ~clk;

  i2c_master_avalon #(.CLK_DIV(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .address   (address),
    .write     (write),
    .writedata (writedata),
    .read      (read),
    .readdata  (readdata),
    .scl       (scl),
    .sda       (sda)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- behavioural slave ----------------
  logic [7:0] rd_bytes [0:7];
  logic [7:0] byte_log [0:63];
  logic       ack_log  [0:63];
  int   rise_cnt = 0, stop_cnt = 0, nlog = 0, nack = 0;
  int   bit_cnt = 0, byte_cnt = 0;
  logic [7:0] sh = 8'd0;
  logic matched = 1'b0, is_read = 1'b0, mnack = 1'b0;
  logic scl_q = 1'b1, sda_q = 1'b1;

  always @(negedge clk) begin
    if (scl === 1'b1 && scl_q === 1'b0) begin
      rise_cnt++;
      if (bit_cnt < 8) begin
        sh = {sh[6:0], sda};
        if (bit_cnt == 7) begin
          if (nlog < 64) byte_log[nlog] = sh;
          nlog++;
          if (byte_cnt == 0) begin
            matched = sl_present && (sh[7:1] == SLV);
            is_read = sh[0];
          end
        end
      end else if (bit_cnt == 8 && is_read && byte_cnt >= 1) begin
        if (nack < 64) ack_log[nack] = sda;
        nack++;
        if (sda === 1'b1) mnack = 1'b1;
      end
      bit_cnt++;
    end else if (scl === 1'b0 && scl_q === 1'b1) begin
      if (bit_cnt >= 9) begin
        bit_cnt = 0;
        byte_cnt++;
      end
      sl_low = 1'b0;
      if (matched) begin
        if (bit_cnt == 8)
          sl_low = (byte_cnt == 0) || !is_read;
        else if (bit_cnt < 8 && is_read && byte_cnt >= 1 && byte_cnt <= 8 && !mnack)
          sl_low = ~rd_bytes[byte_cnt-1][7-bit_cnt];
      end
    end else if (scl === 1'b1 && scl_q === 1'b1 && sda_q === 1'b1 && sda === 1'b0) begin
      bit_cnt = 0;
      byte_cnt = 0;
      matched = 1'b0;
      is_read = 1'b0;
      mnack = 1'b0;
      sl_low = 1'b0;
    end else if (scl === 1'b1 && scl_q === 1'b1 && sda_q === 1'b0 && sda === 1'b1) begin
      stop_cnt++;
      sl_low = 1'b0;
    end
    scl_q = scl;
    sda_q = sda;
  end

  // ---------------- bus tasks ----------------
  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    address = a; writedata = d; write = 1'b1;
    @(negedge clk);
    write = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    address = a; read = 1'b1;
    @(negedge clk);
    read = 1'b0;
    d = readdata;
  endtask

  // Polls STATUS every cycle and returns the number of cycles busy was seen high.
  task automatic wait_idle(output int cyc);
    cyc = 0;
    address = 2'd2; read = 1'b1;
    forever begin
      @(negedge clk);
      if (readdata[0] !== 1'b1) break;
      cyc++;
      if (cyc > 5000) begin
        n_checks++;
        n_fail++;
        $display("FAIL wait_idle: busy still set after %0d cycles, expected clear", cyc);
        break;
      end
    end
    read = 1'b0;
  endtask

  // Holds SCL low across the released phase of the 4th data bit.
  task automatic do_stretch(input int base);
    logic prev;
    int   guard;
    prev  = 1'b1;
    guard = 0;
    while (guard < 4000) begin
      @(negedge clk);
      guard++;
      if ((rise_cnt - base) >= 12 && prev === 1'b1 && scl === 1'b0) break;
      prev = scl;
    end
    tb_scl_low = 1'b1;
    repeat (58) @(negedge clk);
    tb_scl_low = 1'b0;
  endtask

  logic [31:0] d;
  int lat, b0, r0, s0, a0, guard;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 8; i++) rd_bytes[i] = 8'h00;
    rd_bytes[0] = 8'h11; rd_bytes[1] = 8'h22; rd_bytes[2] = 8'h33; rd_bytes[3] = 8'h44;
    reset = 1'b1; write = 1'b0; read = 1'b0; address = 2'd0; writedata = 32'd0;
    repeat (3) @(negedge clk);
    check_eq("rst_readdata", readdata, 32'd0);
    check_eq("rst_scl", {31'd0, scl}, 32'd1);
    check_eq("rst_sda", {31'd0, sda}, 32'd1);
    reset = 1'b0;
    bus_read(2'd2, d); check_eq("rst_status", d, 32'd0);
    bus_read(2'd1, d); check_eq("rst_txdata", d, 32'd0);

    bus_write(2'd0, 32'h50);
    bus_write(2'd1, 32'hA5);
    bus_read(2'd0, d); check_eq("slave_addr_rb", d, 32'h50);
    bus_read(2'd1, d); check_eq("tx_data_rb", d, 32'hA5);

    // Single-byte write
    b0 = nlog; r0 = rise_cnt; s0 = stop_cnt;
    bus_write(2'd2, 32'h1);
    wait_idle(lat);
    $display("txn write1: latency=%0d cycles", lat);
    check_eq("wr1_latency", lat, 320);
    check_eq("wr1_addr_byte", {24'd0, byte_log[b0]}, 32'hA0);
    check_eq("wr1_data_byte", {24'd0, byte_log[b0+1]}, 32'hA5);
    check_eq("wr1_scl_rises", rise_cnt - r0, 19);
    check_eq("wr1_stop", stop_cnt - s0, 1);
    bus_read(2'd2, d); check_eq("wr1_status", d, 32'd0);

    // Four-byte read
    b0 = nlog; s0 = stop_cnt; a0 = nack;
    bus_write(2'd2, 32'hF);
    wait_idle(lat);
    $display("txn read4: latency=%0d cycles", lat);
    check_eq("rd4_latency", lat, 752);
    bus_read(2'd3, d); check_eq("rd4_rx_data", d, 32'h44332211);
    check_eq("rd4_addr_byte", {24'd0, byte_log[b0]}, 32'hA1);
    check_eq("rd4_acks", {28'd0, ack_log[a0+3], ack_log[a0+2], ack_log[a0+1], ack_log[a0]}, 32'h8);
    check_eq("rd4_stop", stop_cnt - s0, 1);
    bus_read(2'd2, d); check_eq("rd4_status", d, 32'd0);

    // Address NACK
    sl_present = 1'b0;
    r0 = rise_cnt;
    bus_write(2'd2, 32'h1);
    wait_idle(lat);
    $display("txn nack: latency=%0d cycles", lat);
    check_eq("nack_latency", lat, 176);
    bus_read(2'd2, d); check_eq("nack_status", d, 32'h2);
    check_eq("nack_scl_rises", rise_cnt - r0, 10);
    bus_read(2'd3, d); check_eq("nack_rx_cleared", d, 32'd0);
    sl_present = 1'b1;

    // Clock stretch
    bus_write(2'd1, 32'hC3);
    b0 = nlog; r0 = rise_cnt;
    bus_write(2'd2, 32'h1);
    fork
      wait_idle(lat);
      do_stretch(r0);
    join
    $display("txn stretch: latency=%0d cycles", lat);
    check_eq("str_latency", lat, 370);
    check_eq("str_data_byte", {24'd0, byte_log[b0+1]}, 32'hC3);
    bus_read(2'd2, d); check_eq("str_status", d, 32'd0);

    // Busy protection
    bus_write(2'd1, 32'h3C);
    b0 = nlog; r0 = rise_cnt;
    bus_write(2'd2, 32'h1);
    bus_write(2'd1, 32'hFF);
    bus_write(2'd2, 32'h1);
    bus_read(2'd1, d); check_eq("busy_tx_data_kept", d, 32'h3C);
    wait_idle(lat);
    $display("txn busy_prot: remaining=%0d cycles", lat);
    check_eq("busy_data_byte", {24'd0, byte_log[b0+1]}, 32'h3C);
    repeat (60) @(negedge clk);
    check_eq("busy_no_second_txn", rise_cnt - r0, 19);
    bus_read(2'd2, d); check_eq("busy_status", d, 32'd0);

    // Simultaneous read and write returns the pre-write value
    @(negedge clk);
    address = 2'd1; writedata = 32'h0000_1234; write = 1'b1; read = 1'b1;
    @(negedge clk);
    write = 1'b0; read = 1'b0;
    check_eq("rw_pre_value", readdata, 32'h3C);
    bus_read(2'd1, d); check_eq("rw_post_value", d, 32'h1234);

    // Reset mid-byte
    bus_write(2'd1, 32'hA5);
    r0 = rise_cnt;
    bus_write(2'd2, 32'h1);
    guard = 0;
    while ((rise_cnt - r0) < 4 && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_eq("mid_rst_scl", {31'd0, scl}, 32'd1);
    check_eq("mid_rst_sda", {31'd0, sda}, 32'd1);
    $display("txn reset_mid_byte: reset applied after %0d scl rises", rise_cnt - r0);
    bus_read(2'd2, d); check_eq("mid_rst_status", d, 32'd0);
    bus_read(2'd0, d); check_eq("mid_rst_slave_addr", d, 32'd0);
    bus_write(2'd0, 32'h50);
    bus_write(2'd1, 32'h96);
    b0 = nlog;
    bus_write(2'd2, 32'h1);
    wait_idle(lat);
    $display("txn after_reset: latency=%0d cycles", lat);
    check_eq("post_rst_latency", lat, 320);
    check_eq("post_rst_addr_byte", {24'd0, byte_log[b0]}, 32'hA0);
    check_eq("post_rst_data_byte", {24'd0, byte_log[b0+1]}, 32'h96);
    bus_read(2'd2, d); check_eq("post_rst_status", d, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
